// File: rtl/scan_mux.sv
// scan_mux: registered N-channel, W-bit multiplexer with manual or round-robin scan
// selection and a valid/ready output stage.
//
// Optional feature: define SCAN_MUX_SKIP_EN to add the per-channel scan enable
// port ch_en. Scan mode then skips disabled channels. With every channel
// disabled, nothing is loaded.
//
// N must be a power of two. This lets the scan pointer wrap by plain SEL_W-bit
// overflow.
module scan_mux #(
  parameter int unsigned W     = 1,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   din,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  input  logic             hold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     dout,
  output logic [SEL_W-1:0] out_ch
`ifdef SCAN_MUX_SKIP_EN
  ,
  input  logic [N-1:0]     ch_en
`endif
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [W-1:0]       dout_q;
  logic [SEL_W-1:0]   out_ch_q;

  logic [SEL_W-1:0]   ch;
  logic               avail;
  logic               load;
  logic [W-1:0]       sample;

  // Channel selection: manual index, or the scan pointer (optionally skipping disabled lanes)
  always_comb begin
    ch    = sel;
    avail = 1'b1;
    if (mode) begin
`ifdef SCAN_MUX_SKIP_EN
      ch    = ptr_q;
      avail = 1'b0;
      // Walk offsets from farthest to nearest so the nearest enabled lane wins
      for (int unsigned i = N; i > 0; i--) begin
        logic [SEL_W-1:0] idx;
        idx = ptr_q + SEL_W'(i - 1);
        if (ch_en[idx]) begin
          avail = 1'b1;
          ch    = idx;
        end
      end
`else
      ch = ptr_q;
`endif
    end
  end

  // Capture whenever the output slot is free or being drained this cycle
  always_comb begin
    load   = !hold && (!out_valid || out_ready) && avail;
    sample = din[int'(ch) * W +: W];
  end

  // Output FSM with registered sample, channel tag and scan pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEmpty;
      ptr_q    <= '0;
      dout_q   <= '0;
      out_ch_q <= '0;
    end else begin
      if (load) begin
        dout_q   <= sample;
        out_ch_q <= ch;
        if (mode) ptr_q <= ch + SEL_W'(1);
      end
      case (state_q)
        StEmpty: if (load) state_q <= StFull;
        StFull:  if (!load && out_ready) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign out_valid = (state_q == StFull);
  assign dout      = dout_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed scenarios plus randomized traffic checked against a
// behavioural model of the sample slot and scan pointer.
module tb_scan_mux;

  localparam int W = 8;
  localparam int N = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   din;
  logic [SEL_W-1:0] sel;
  logic             mode;
  logic             hold;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     dout;
  logic [SEL_W-1:0] out_ch;
`ifdef SCAN_MUX_SKIP_EN
  logic [N-1:0]     ch_en;
`endif

  int tests = 0;
  int fails = 0;

  // Model state
  bit      m_valid;
  int      m_dout;
  int      m_ch;
  int      m_ptr;

  scan_mux #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .sel       (sel),
    .mode      (mode),
    .hold      (hold),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_ch    (out_ch)
`ifdef SCAN_MUX_SKIP_EN
    ,
    .ch_en     (ch_en)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_dout  = 0;
    m_ch    = 0;
    m_ptr   = 0;
  endtask

  // Apply the rules for one clock edge with the inputs currently driven
  task automatic model_step();
    bit avail;
    int c;
    bit ld;
    avail = 1;
    c     = sel;
    if (mode) begin
`ifdef SCAN_MUX_SKIP_EN
      avail = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (ch_en[(m_ptr + k) % N]) begin
          avail = 1;
          c     = (m_ptr + k) % N;
        end
      end
`else
      c = m_ptr;
`endif
    end
    ld = !hold && (!m_valid || out_ready) && avail;
    if (ld) begin
      m_dout  = (din >> (c * W)) & 8'hff;
      m_ch    = c;
      m_valid = 1;
      if (mode) m_ptr = (c + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, int'(out_valid), int'(m_valid));
    check({tag, ".dout"},  int'(dout),      m_dout);
    check({tag, ".ch"},    int'(out_ch),    m_ch);
  endtask

  // One clock: model advances, DUT advances, compare on the falling edge
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  // Asynchronous reset pulse asserted away from any clock edge
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    @(negedge clk);
    compare_all("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    din       = 32'h44332211;
    sel       = '0;
    mode      = 1'b0;
    hold      = 1'b0;
    out_ready = 1'b1;
`ifdef SCAN_MUX_SKIP_EN
    ch_en     = '1;
`endif
    model_reset();
    #3;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Manual select of channel 2
    sel = 2'd2;
    cycle("manual");
    check("manual.dout_const", int'(dout), 8'h33);
    check("manual.ch_const", int'(out_ch), 2);

    // Scan from pointer 0, untouched by manual mode
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle("scan");
      check("scan.seq", int'(out_ch), i % 4);
      check("scan.dout_seq", int'(dout), 8'h11 * ((i % 4) + 1));
    end

    // Backpressure right after the first sample following reset
    pulse_reset();
    cycle("bp_first");
    check("bp_first.ch", int'(out_ch), 0);
    out_ready = 1'b0;
    sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall");
      check("bp_stall.ch", int'(out_ch), 0);
      check("bp_stall.dout", int'(dout), 8'h11);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    check("bp_release.ch", int'(out_ch), 1);

    // Hold drains the slot and keeps it empty
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("hold");
      check("hold.valid", int'(out_valid), 0);
    end
    hold = 1'b0;
    cycle("hold_release");
    check("hold_release.valid", int'(out_valid), 1);

    // Reset mid-stream with a sample pending; scan restarts at channel 0
    din = 32'hdeadbeef;
    pulse_reset();
    mode = 1'b1;
    cycle("post_rst");
    check("post_rst.ch", int'(out_ch), 0);

`ifdef SCAN_MUX_SKIP_EN
    pulse_reset();
    ch_en = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle("skip");
      check("skip.seq", int'(out_ch), (i % 2 == 0) ? 1 : 3);
    end
    ch_en = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cycle("skip_none");
      check("skip_none.valid", int'(out_valid), 0);
    end
    ch_en = '1;
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      din       = $urandom;
      sel       = SEL_W'($urandom_range(0, N - 1));
      mode      = ($urandom_range(0, 3) != 0);
      hold      = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef SCAN_MUX_SKIP_EN
      ch_en     = N'($urandom);
`endif
      if (i % 500 == 250) pulse_reset();
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
